// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter states,
// status-register bit positions and default timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_t;

    localparam int unsigned TX_STAT_BUSY   = 0;
    localparam int unsigned ACK_TO_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searched in modulo order. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned PW = $clog2(NREQ);

    always_comb begin
        logic          found;
        logic [PW-1:0] pos;
        int unsigned   k;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k   = (32'(ptr) + i) % NREQ;
            pos = PW'(k);
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one uart_tx between NREQ byte producers,
// with optional per-message grant lock and strobe re-issue on missing ack.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LOCK_EN = 1,
    parameter int unsigned ACK_TO  = ACK_TO_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ-1:0]      i_req_last,
    input  logic [8*NREQ-1:0]    i_req_dat,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_tx_cyc,
    output logic                 o_tx_we,
    output logic [7:0]           o_tx_dat,
    input  logic [7:0]           i_tx_stat,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    arb_state_t        state, state_next;
    logic [PW-1:0]     ptr, ptr_next;
    logic              lock, lock_next;
    logic [CW-1:0]     to_cnt, cnt_next;
    logic [7:0]        hold_dat, hold_dat_next;
    logic              hold_last, hold_last_next;
    logic [NREQ-1:0]   grant, grant_next;
    logic [NREQ-1:0]   eligible, arb_grant;
    logic [PW-1:0]     arb_idx;
    logic [7:0]        sel_dat;
    logic              sel_last;
    logic              tx_busy;
    logic              stat_unused;

    assign tx_busy     = i_tx_stat[TX_STAT_BUSY];
    assign stat_unused = ^i_tx_stat[7:1];

    // While a message lock is held only the owner may win; others are masked out.
    assign eligible = lock ? (i_req_valid & grant) : i_req_valid;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (eligible),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        sel_dat = '0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            if (arb_grant[n]) sel_dat = i_req_dat[8*n +: 8];
        end
    end

    assign sel_last = |(arb_grant & i_req_last);

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        lock_next      = lock;
        cnt_next       = to_cnt;
        hold_dat_next  = hold_dat;
        hold_last_next = hold_last;
        grant_next     = grant;
        o_req_ready    = '0;
        o_tx_cyc       = 1'b0;
        o_tx_we        = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && (|arb_grant)) begin
                    o_req_ready    = arb_grant;
                    hold_dat_next  = sel_dat;
                    hold_last_next = sel_last;
                    grant_next     = arb_grant;
                    ptr_next       = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                o_tx_cyc   = 1'b1;
                o_tx_we    = 1'b1;
                cnt_next   = CW'(ACK_TO - 1);
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy)              state_next = WAIT_DONE;
                else if (to_cnt == '0)    state_next = ISSUE;
                else                      cnt_next   = to_cnt - 1'b1;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                    lock_next  = (LOCK_EN != 0) && !hold_last;
                    if (!lock_next) grant_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lock      <= 1'b0;
            to_cnt    <= '0;
            hold_dat  <= '0;
            hold_last <= 1'b0;
            grant     <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            lock      <= lock_next;
            to_cnt    <= cnt_next;
            hold_dat  <= hold_dat_next;
            hold_last <= hold_last_next;
            grant     <= grant_next;
        end
    end

    assign o_tx_dat = hold_dat;
    assign o_grant  = grant;
    assign o_busy   = (state != IDLE) || lock;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a transaction-level arbitration model
// plus a behavioural uart_tx that logs every byte it puts on the line.
module tb_uart_tx_arb;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ACK_TO = 4;
    localparam int unsigned FRAME  = 12;

    logic                i_clk = 1'b0;
    logic                i_reset_n = 1'b1;
    logic [NREQ-1:0]     i_req_valid = '0;
    logic [NREQ-1:0]     i_req_last = '0;
    logic [8*NREQ-1:0]   i_req_dat = '0;
    logic [NREQ-1:0]     o_req_ready;
    logic                o_tx_cyc;
    logic                o_tx_we;
    logic [7:0]          o_tx_dat;
    logic [7:0]          i_tx_stat = 8'b1010_1010;
    logic [NREQ-1:0]     o_grant;
    logic                o_busy;

    always #5 i_clk = ~i_clk;

    uart_tx_arb #(.NREQ(NREQ), .LOCK_EN(1), .ACK_TO(ACK_TO)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .i_req_dat   (i_req_dat),
        .o_req_ready (o_req_ready),
        .o_tx_cyc    (o_tx_cyc),
        .o_tx_we     (o_tx_we),
        .o_tx_dat    (o_tx_dat),
        .i_tx_stat   (i_tx_stat),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    // Transmitter model: busy two cycles after a strobe, for FRAME cycles;
    // unaffected by the arbiter reset. The first deaf_budget strobes are ignored.
    logic [7:0]  line_q[$];
    logic        line_busy = 1'b0;
    int unsigned delay = 0, frame = 0, ignored = 0, deaf_budget = 0;

    always @(negedge i_clk) begin
        if (delay != 0) begin
            delay--;
            if (delay == 0) begin
                line_busy = 1'b1;
                frame     = FRAME;
            end
        end else if (line_busy) begin
            frame--;
            if (frame == 0) line_busy = 1'b0;
        end
        if (o_tx_cyc && o_tx_we && !line_busy && delay == 0) begin
            if (ignored < deaf_budget) ignored++;
            else begin
                line_q.push_back(o_tx_dat);
                delay = 2;
            end
        end
        i_tx_stat = {7'b1010101, line_busy};
    end

    int          n_assert = 0, n_fail = 0;
    logic [8:0]  mem [NREQ][64];
    int unsigned head [NREQ], tail [NREQ];
    logic [NREQ-1:0] gate = '1;
    bit          rnd_gate = 1'b0, strict = 1'b1;
    int          m_ptr = 0, m_lock = -1, m_owner = 0;
    bit          m_inflight = 1'b0, m_seen_busy = 1'b0, m_hold_last = 1'b0;
    logic [7:0]  m_last_byte = '0;
    int          since = 100, cyc_no = 0, line_base = 0;
    int          strobe_cyc[$];
    logic [7:0]  exp_line[$], want[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [7:0] d, input bit last);
        mem[n][tail[n]] = {last, d};
        tail[n]++;
    endtask

    function automatic bit all_empty();
        for (int n = 0; n < NREQ; n++) if (head[n] != tail[n]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic phase_start();
        for (int n = 0; n < NREQ; n++) begin head[n] = 0; tail[n] = 0; end
        exp_line.delete();
        want.delete();
        strobe_cyc.delete();
        line_base = line_q.size();
    endtask

    task automatic reset_checks();
        chk("rst ready", o_req_ready, '0);
        chk("rst grant", o_grant, '0);
        chk("rst busy", o_busy, 1'b0);
        chk("rst tx_cyc", o_tx_cyc, 1'b0);
        chk("rst tx_we", o_tx_we, 1'b0);
        chk("rst tx_dat", o_tx_dat, 8'h00);
    endtask

    task automatic cycle();
        logic [NREQ-1:0] v, elig, exp_ready, exp_grant;
        int w;
        @(negedge i_clk);
        cyc_no++;
        since++;
        if (rnd_gate) for (int n = 0; n < NREQ; n++) gate[n] = ($urandom_range(0, 3) != 0);
        for (int n = 0; n < NREQ; n++) begin
            v[n] = (head[n] != tail[n]) && gate[n];
            i_req_dat[8*n +: 8] = mem[n][head[n]][7:0];
            i_req_last[n]       = mem[n][head[n]][8];
        end
        i_req_valid = v;
        #1;
        w = -1;
        exp_ready = '0;
        if (!m_inflight && i_tx_stat[0] == 1'b0) begin
            elig = (m_lock >= 0) ? (v & (NREQ'(1) << m_lock)) : v;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) exp_ready = NREQ'(1) << w;
        end
        if (m_inflight)       exp_grant = NREQ'(1) << m_owner;
        else if (m_lock >= 0) exp_grant = NREQ'(1) << m_lock;
        else                  exp_grant = '0;
        chk("ready", o_req_ready, exp_ready);
        chk("grant", o_grant, exp_grant);
        chk("busy", o_busy, m_inflight || (m_lock >= 0));
        chk("tx_dat", o_tx_dat, m_last_byte);
        if (o_tx_cyc === 1'b1) strobe_cyc.push_back(cyc_no);
        if (strict) chk("strobe", {o_tx_cyc, o_tx_we}, (since == 1) ? 2'b11 : 2'b00);
        else        chk("strobe_we", o_tx_we, o_tx_cyc);
        if (m_inflight) begin
            if (i_tx_stat[0]) m_seen_busy = 1'b1;
            else if (m_seen_busy) begin
                m_inflight = 1'b0;
                m_lock     = m_hold_last ? -1 : m_owner;
            end
        end
        if (w >= 0) begin
            m_last_byte = mem[w][head[w]][7:0];
            m_hold_last = mem[w][head[w]][8];
            exp_line.push_back(m_last_byte);
            head[w]++;
            m_inflight  = 1'b1;
            m_seen_busy = 1'b0;
            m_owner     = w;
            m_ptr       = (w + 1) % NREQ;
            since       = 0;
        end
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned k = 0;
        while (k < budget && !(all_empty() && !m_inflight && m_lock < 0 && i_tx_stat[0] == 1'b0)) begin
            cycle();
            k++;
        end
        chk({tag, " drain_in_budget"}, k < budget, 1'b1);
    endtask

    task automatic check_line(input string tag);
        chk({tag, " line_len"}, line_q.size() - line_base, exp_line.size());
        for (int i = 0; i < exp_line.size(); i++)
            if (line_base + i < line_q.size()) chk({tag, " line_byte"}, line_q[line_base + i], exp_line[i]);
        if (want.size() != 0) begin
            chk({tag, " model_len"}, exp_line.size(), want.size());
            for (int i = 0; i < want.size(); i++)
                if (line_base + i < line_q.size()) chk({tag, " line_const"}, line_q[line_base + i], want[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int gap;
        #2 i_reset_n = 1'b0;
        #1 reset_checks();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        // Fairness: every byte ends its message, so arbitration is pure round-robin.
        phase_start();
        push(0, 8'h00, 1); push(0, 8'h00, 1);
        push(1, 8'h01, 1); push(2, 8'h02, 1); push(3, 8'h03, 1);
        want = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        drain("fair", 600);
        check_line("fair");

        phase_start();
        push(0, 8'h55, 1);
        want = '{8'h55};
        drain("single", 100);
        check_line("single");

        // Lock: requester 1 becomes valid only after 'A' is accepted.
        phase_start();
        gate[1] = 1'b0;
        push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
        push(1, 8'h78, 1); push(1, 8'h79, 1);
        k = 0;
        while (!m_inflight && k < 50) begin cycle(); k++; end
        chk("lock first_accept_in_budget", k < 50, 1'b1);
        gate[1] = 1'b1;
        want = '{8'h41, 8'h42, 8'h43, 8'h78, 8'h79};
        drain("lock", 600);
        check_line("lock");

        // Timeout: the transmitter ignores the first strobe.
        phase_start();
        deaf_budget = deaf_budget + 1;
        strict = 1'b0;
        push(0, 8'h5A, 1); push(1, 8'h6B, 1);
        want = '{8'h5A, 8'h6B};
        drain("timeout", 300);
        strict = 1'b1;
        check_line("timeout");
        chk("timeout strobe_count", strobe_cyc.size(), 3);
        if (strobe_cyc.size() >= 2) begin
            gap = strobe_cyc[1] - strobe_cyc[0];
            chk("timeout restrobe_gap", (gap >= ACK_TO) && (gap <= ACK_TO + 1), 1'b1);
        end

        // Reset during WAIT_DONE while the transmitter stays busy.
        phase_start();
        push(2, 8'h33, 1);
        k = 0;
        while (!(m_inflight && m_seen_busy) && k < 50) begin cycle(); k++; end
        chk("reset reach_wait_done", k < 50, 1'b1);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1 reset_checks();
        m_inflight = 1'b0; m_lock = -1; m_ptr = 0; m_last_byte = '0; since = 100;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        push(0, 8'h44, 1); push(1, 8'h55, 1); push(3, 8'h66, 1);
        want = '{8'h33, 8'h44, 8'h55, 8'h66};
        drain("reset", 300);
        check_line("reset");

        // Random messages with randomly dropping valids.
        phase_start();
        for (int n = 0; n < NREQ; n++) begin
            int unsigned nm = $urandom_range(1, 3);
            for (int unsigned m = 0; m < nm; m++) begin
                int unsigned len = $urandom_range(1, 3);
                for (int unsigned b = 0; b < len; b++)
                    push(n, 8'($urandom_range(0, 255)), b == len - 1);
            end
        end
        rnd_gate = 1'b1;
        drain("random", 5000);
        rnd_gate = 1'b0;
        gate = '1;
        check_line("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
